systolic_sequencer: RTL

- Sequencing controller for the 4x4 8-bit systolic array wrapper (eight shift_buffer instances plus PEarray).
- Accepts a start request and pulls one column of A and one row of B per beat from an upstream source, using a valid/ready handshake.
- Generates skewed load positions, then the shift window, then the OutputSign drain window with downstream backpressure.
- Reports busy and done to the host.

---
 rtl/systolic_sequencer_pkg.sv | 25 ++
 rtl/systolic_sequencer_skew_id_gen.sv | 17 +
 rtl/systolic_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/systolic_sequencer_pkg.sv
// Shared types and constants for the systolic array sequencer.
// The array geometry is fixed here; all other files import it.
package systolic_sequencer_pkg;

   localparam int N              = 4;
   localparam int ID_W           = 3;
   localparam int COMPUTE_CYCLES = 3 * N - 2;
   localparam int CC_W           = $clog2(COMPUTE_CYCLES);
   localparam int IDX_W          = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_COMPUTE = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // Lane i of beat k lands at position k+i, producing the diagonal skew.
   function automatic logic [ID_W-1:0] skew_pos(input logic [IDX_W-1:0] k,
                                                input int unsigned       lane);
      return ID_W'(k) + ID_W'(lane);
   endfunction

endpackage

// File: rtl/systolic_sequencer_skew_id_gen.sv
// Combinational skewed load-position generator for the A row and B column buffers.
// Positions are forced to zero whenever no beat is being loaded.
module skew_id_gen
   import systolic_sequencer_pkg::*;
(
   input  logic             en,
   input  logic [IDX_W-1:0] k,
   output logic [ID_W-1:0]  id_a [N],
   output logic [ID_W-1:0]  id_b [N]
);

   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign id_a[gi] = en ? skew_pos(k, gi) : '0;
      assign id_b[gi] = en ? skew_pos(k, gi) : '0;
   end

endmodule

// File: rtl/systolic_sequencer.sv
// Job sequencer for the 4x4 systolic array: pulls N operand beats, runs the
// shift window, then drains N result rows under downstream backpressure.
module systolic_sequencer
   import systolic_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   input  logic             src_valid,
   output logic             src_ready,
   output logic [IDX_W-1:0] src_idx,
   output logic             load,
   output logic             shift,
   output logic             output_sign,
   output logic [ID_W-1:0]  id_A_0,
   output logic [ID_W-1:0]  id_A_1,
   output logic [ID_W-1:0]  id_A_2,
   output logic [ID_W-1:0]  id_A_3,
   output logic [ID_W-1:0]  id_B_0,
   output logic [ID_W-1:0]  id_B_1,
   output logic [ID_W-1:0]  id_B_2,
   output logic [ID_W-1:0]  id_B_3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx
);

   state_t           state_reg, state_next;
   logic [IDX_W-1:0] k_reg, k_next;
   logic [CC_W-1:0]  cc_reg, cc_next;
   logic [IDX_W-1:0] r_reg, r_next;

   logic             in_load;
   logic             in_compute;
   logic             in_drain;
   logic [ID_W-1:0]  id_a [N];
   logic [ID_W-1:0]  id_b [N];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         k_reg     <= '0;
         cc_reg    <= '0;
         r_reg     <= '0;
      end else begin
         state_reg <= state_next;
         k_reg     <= k_next;
         cc_reg    <= cc_next;
         r_reg     <= r_next;
      end
   end

   // Counters stop on their last value instead of wrapping; the next phase
   // entry clears them explicitly.
   always_comb begin
      state_next = state_reg;
      k_next     = k_reg;
      cc_next    = cc_reg;
      r_next     = r_reg;
      unique case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_LOAD;
               k_next     = '0;
            end
         end
         ST_LOAD: begin
            if (src_valid) begin
               if (k_reg == IDX_W'(N - 1)) begin
                  state_next = ST_COMPUTE;
                  cc_next    = '0;
               end else begin
                  k_next = k_reg + IDX_W'(1);
               end
            end
         end
         ST_COMPUTE: begin
            if (cc_reg == CC_W'(COMPUTE_CYCLES - 1)) begin
               state_next = ST_DRAIN;
               r_next     = '0;
            end else begin
               cc_next = cc_reg + CC_W'(1);
            end
         end
         ST_DRAIN: begin
            if (out_ready) begin
               if (r_reg == IDX_W'(N - 1)) begin
                  state_next = ST_DONE;
               end else begin
                  r_next = r_reg + IDX_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign in_load    = (state_reg == ST_LOAD);
   assign in_compute = (state_reg == ST_COMPUTE);
   assign in_drain   = (state_reg == ST_DRAIN);

   // Strobes qualify the handshake inputs by state, so at most one is high.
   always_comb begin
      busy        = in_load || in_compute || in_drain;
      done        = (state_reg == ST_DONE);
      src_ready   = in_load;
      src_idx     = in_load ? k_reg : '0;
      load        = in_load && src_valid;
      shift       = in_compute;
      output_sign = in_drain && out_ready;
      out_valid   = in_drain;
      out_idx     = in_drain ? r_reg : '0;
   end

   skew_id_gen u_skew (
      .en   (in_load),
      .k    (k_reg),
      .id_a (id_a),
      .id_b (id_b)
   );

   assign id_A_0 = id_a[0];
   assign id_A_1 = id_a[1];
   assign id_A_2 = id_a[2];
   assign id_A_3 = id_a[3];
   assign id_B_0 = id_b[0];
   assign id_B_1 = id_b[1];
   assign id_B_2 = id_b[2];
   assign id_B_3 = id_b[3];

endmodule
